// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage sitting directly in front of the instruction RAM.
// Owns the program counter, drives the RAM pins (always in read mode), captures
// the combinational read data into a small in-order {pc, instr} prefetch queue
// and hands the queue head to decode over a valid/ready handshake. A redirect
// flushes the queue and restarts fetching at a new address. Fetching stops
// after a word equal to HALT_WORD has been pushed.
//
// Optional feature macro: INSTR_FETCH_PERF_EN
//   When defined, adds saturating fetch_count / stall_count outputs.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start          in   leave IDLE and begin fetching at the current PC
//   mem_en         out  RAM enable, high only in a fetch cycle
//   mem_rw         out  RAM read/write select, constant 1 (read)
//   mem_addr       out  RAM word address (= pc)
//   mem_rdata      in   RAM read data, valid in the same cycle as mem_addr
//   redirect_valid in   branch/jump taken
//   redirect_pc    in   new fetch address
//   out_valid      out  queue head valid
//   out_ready      in   decode accepts the head
//   out_instr      out  head instruction
//   out_pc         out  address of the head instruction
//   halted         out  fetch stopped on HALT_WORD
//   fetch_count    out  (INSTR_FETCH_PERF_EN) number of fetch cycles
//   stall_count    out  (INSTR_FETCH_PERF_EN) RUN cycles with a full queue
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int              A         = 16,
  parameter int              W         = 32,
  parameter int              DEPTH     = 2,
  parameter logic [A-1:0]    RESET_PC  = {A{1'b0}},
  parameter logic [W-1:0]    HALT_WORD = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         mem_en,
  output logic         mem_rw,
  output logic [A-1:0] mem_addr,
  input  logic [W-1:0] mem_rdata,
  input  logic         redirect_valid,
  input  logic [A-1:0] redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_instr,
  output logic [A-1:0] out_pc,
  output logic         halted
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0]  fetch_count,
  output logic [31:0]  stall_count
`endif
);

  // Counter must hold 0..DEPTH inclusive; queue index needs log2(DEPTH) bits.
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [A-1:0]            pc_q, pc_d;
  logic                    halted_q, halted_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    out_valid_q;
  // Entry 0 is always the queue head, so the head is itself a register and
  // feeds out_pc/out_instr directly.
  logic [DEPTH-1:0][A-1:0] qpc_q, qpc_d;
  logic [DEPTH-1:0][W-1:0] qin_q, qin_d;

  logic                    full_s;
  logic                    fetch_s;
  logic                    pop_s;
  logic                    halt_hit_s;
  logic [CW-1:0]           wr_idx_s;

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0]             fetch_cnt_q;
  logic [31:0]             stall_cnt_q;
`endif

  // Fetch/pop qualification; redirect suppresses both.
  always_comb begin
    full_s     = (count_q == CW'(DEPTH));
    fetch_s    = (state_q == ST_RUN) && !redirect_valid && !full_s;
    pop_s      = (count_q != {CW{1'b0}}) && out_ready && !redirect_valid;
    halt_hit_s = fetch_s && (mem_rdata == HALT_WORD);
  end

  // Next state, program counter and halt flag.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      halted_d = 1'b0;
      // In IDLE a redirect only loads the PC; start is still honoured.
      if (state_q == ST_IDLE) begin
        state_d = start ? ST_RUN : ST_IDLE;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (fetch_s) begin
            pc_d = pc_q + {{(A-1){1'b0}}, 1'b1};
          end else begin
            pc_d = pc_q;
          end
          // The halt word itself is pushed; fetching stops afterwards.
          if (halt_hit_s) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d  = ST_RUN;
          end
        end
        ST_HALT: begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end
        default: begin
          state_d  = ST_IDLE;
          halted_d = 1'b0;
        end
      endcase
    end
  end

  // Prefetch queue next state: shift on pop, write behind the last live entry.
  always_comb begin
    qpc_d    = qpc_q;
    qin_d    = qin_q;
    count_d  = count_q;
    wr_idx_s = count_q;
    if (redirect_valid) begin
      count_d = {CW{1'b0}};
    end else begin
      if (pop_s) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          qpc_d[i] = qpc_q[i+1];
          qin_d[i] = qin_q[i+1];
        end
        wr_idx_s = count_q - CW'(1);
        count_d  = count_q - CW'(1);
      end else begin
        wr_idx_s = count_q;
        count_d  = count_q;
      end
      // fetch_s implies count_q < DEPTH, so wr_idx_s is always in range.
      if (fetch_s) begin
        qpc_d[wr_idx_s[IW-1:0]] = pc_q;
        qin_d[wr_idx_s[IW-1:0]] = mem_rdata;
        count_d                 = count_d + CW'(1);
      end else begin
        count_d = count_d;
      end
    end
  end

  // FSM, PC, queue and registered handshake state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      halted_q    <= 1'b0;
      count_q     <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      qpc_q       <= '0;
      qin_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      halted_q    <= halted_d;
      count_q     <= count_d;
      out_valid_q <= (count_d != {CW{1'b0}});
      qpc_q       <= qpc_d;
      qin_q       <= qin_d;
    end
  end

`ifdef INSTR_FETCH_PERF_EN
  // Saturating performance counters; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      if (fetch_s && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'h0000_0001;
      end else begin
        fetch_cnt_q <= fetch_cnt_q;
      end
      if ((state_q == ST_RUN) && full_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'h0000_0001;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

  // RAM side: enable must follow redirect within the cycle, so it is decoded
  // from registered state plus redirect_valid; the address is the PC register.
  assign mem_en    = fetch_s;
  assign mem_rw    = 1'b1;
  assign mem_addr  = pc_q;

  assign out_valid = out_valid_q;
  assign out_instr = qin_q[0];
  assign out_pc    = qpc_q[0];
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. A RAM array supplies mem_rdata. The
// reference model is a delivery scoreboard: after reset or a redirect to P,
// decode must see P, P+1, ... (16-bit wrap) with matching RAM contents, up to
// and including the first halt word, and nothing further until a redirect.
// Directed checks cover latency, backpressure, redirect, wrap and reset;
// a randomized phase exercises random ready, redirects and halt placements.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] HALT_W = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mem_en;
  logic        mem_rw;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;
`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic [31:0] mem [0:65535];

  int          total_cnt;
  int          bad_cnt;
  logic [15:0] exp_pc;
  logic        halt_seen;
  int          n_deliv;
  int          n_fetch;
  logic [15:0] last_fetch_addr;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .mem_en         (mem_en),
    .mem_rw         (mem_rw),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
`ifdef INSTR_FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total_cnt++;
    if (obs !== exp_v) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    exp_pc    = 16'h0000;
    halt_seen = 1'b0;
  endtask

  // One clock cycle: observe the cycle's handshake against the model, then
  // advance to just after the next rising edge.
  task automatic cycle();
    #1;
    if (halt_seen && !redirect_valid) begin
      check_val("halt_no_fetch", {63'd0, mem_en}, 64'd0);
    end
    if (redirect_valid) begin
      exp_pc    = redirect_pc;
      halt_seen = 1'b0;
    end else if (out_valid && out_ready) begin
      if (halt_seen) begin
        check_val("valid_after_halt", {63'd0, out_valid}, 64'd0);
      end else begin
        check_val("sb_pc", {48'd0, out_pc}, {48'd0, exp_pc});
        check_val("sb_instr", {32'd0, out_instr}, {32'd0, mem[exp_pc]});
        n_deliv++;
        if (mem[exp_pc] == HALT_W) halt_seen = 1'b1;
        exp_pc = exp_pc + 16'd1;
      end
    end
    if (mem_en) begin
      n_fetch++;
      last_fetch_addr = mem_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    start          = 1'b0;
    redirect_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_val({pfx, "_mem_en"},    {63'd0, mem_en},    64'd0);
    check_val({pfx, "_mem_rw"},    {63'd0, mem_rw},    64'd1);
    check_val({pfx, "_mem_addr"},  {48'd0, mem_addr},  64'd0);
    check_val({pfx, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check_val({pfx, "_out_instr"}, {32'd0, out_instr}, 64'd0);
    check_val({pfx, "_out_pc"},    {48'd0, out_pc},    64'd0);
    check_val({pfx, "_halted"},    {63'd0, halted},    64'd0);
  endtask

  initial begin
    total_cnt       = 0;
    bad_cnt         = 0;
    n_deliv         = 0;
    n_fetch         = 0;
    last_fetch_addr = 16'h0000;
    rst_n           = 1'b0;
    start           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 16'h0000;
    out_ready       = 1'b0;
    model_reset();
    for (int i = 0; i < 65536; i++) mem[i] = $urandom | 32'h0000_0001;
    mem[9] = HALT_W;

    // Reset state
    #3;
    check_reset_vals("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic fetch: words 0..9, halt at 9
    n_deliv   = 0;
    out_ready = 1'b1;
    start     = 1'b1;
    cycle();
    start = 1'b0;
    #1;
    check_val("basic_f0_en",    {63'd0, mem_en},    64'd1);
    check_val("basic_f0_addr",  {48'd0, mem_addr},  64'd0);
    check_val("basic_f0_valid", {63'd0, out_valid}, 64'd0);
    cycle();
    check_val("basic_lat_valid", {63'd0, out_valid}, 64'd1);
    check_val("basic_lat_pc",    {48'd0, out_pc},    64'd0);
    repeat (9) cycle();
    check_val("basic_pc9",     {48'd0, out_pc}, 64'd9);
    check_val("basic_halted",  {63'd0, halted}, 64'd1);
    check_val("basic_halt_en", {63'd0, mem_en}, 64'd0);
    cycle();
    check_val("basic_ndeliv", n_deliv, 64'd10);
    check_val("basic_empty",  {63'd0, out_valid}, 64'd0);
    repeat (3) cycle();
    check_val("basic_stay_halted", {63'd0, halted}, 64'd1);

    // Backpressure: exactly two fetches, head held
    do_reset();
    mem[9]    = 32'h1234_5679;
    mem[20]   = HALT_W;
    out_ready = 1'b0;
    n_fetch   = 0;
    n_deliv   = 0;
    start     = 1'b1;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    check_val("bp_nfetch",    n_fetch, 64'd2);
    check_val("bp_lastaddr",  {48'd0, last_fetch_addr}, 64'd1);
    check_val("bp_en_off",    {63'd0, mem_en},    64'd0);
    check_val("bp_valid",     {63'd0, out_valid}, 64'd1);
    check_val("bp_hold_pc",   {48'd0, out_pc},    64'd0);
    check_val("bp_hold_inst", {32'd0, out_instr}, {32'd0, mem[0]});
    out_ready = 1'b1;
    repeat (3) cycle();
    check_val("bp_ndeliv", n_deliv, 64'd3);

    // Redirect with a non-empty queue
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0005;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check_val("rd_valid0", {63'd0, out_valid}, 64'd0);
    check_val("rd_en",     {63'd0, mem_en},    64'd1);
    check_val("rd_addr",   {48'd0, mem_addr},  64'd5);
    cycle();
    check_val("rd_valid1", {63'd0, out_valid}, 64'd1);
    check_val("rd_pc",     {48'd0, out_pc},    64'd5);
    repeat (20) cycle();
    check_val("rd_halted", {63'd0, halted}, 64'd1);

    // Halt exit with wrap-around
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check_val("wrap_unhalt", {63'd0, halted}, 64'd0);
    cycle();
    check_val("wrap_pc_ffff", {48'd0, out_pc}, 64'hFFFF);
    cycle();
    check_val("wrap_pc_0", {48'd0, out_pc}, 64'h0000);
    cycle();
    check_val("wrap_pc_1", {48'd0, out_pc}, 64'h0001);
    repeat (25) cycle();
    check_val("wrap_rehalt", {63'd0, halted}, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0002;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check_val("hx_unhalt", {63'd0, halted}, 64'd0);
    cycle();
    check_val("hx_valid", {63'd0, out_valid}, 64'd1);
    check_val("hx_pc",    {48'd0, out_pc},    64'd2);

    // Asynchronous reset mid-RUN
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Redirect together with start in IDLE
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    start          = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    start          = 1'b0;
    #1;
    check_val("idle_rs_en",   {63'd0, mem_en},   64'd1);
    check_val("idle_rs_addr", {48'd0, mem_addr}, 64'h0100);
    cycle();
    check_val("idle_rs_pc", {48'd0, out_pc}, 64'h0100);

`ifdef INSTR_FETCH_PERF_EN
    // Perf counters: 4 fetches then 3 full-stall cycles
    do_reset();
    out_ready = 1'b0;
    start     = 1'b1;
    cycle();
    start = 1'b0;
    begin
      logic [6:0] rdy_seq;
      rdy_seq = 7'b0000110;
      for (int k = 0; k < 7; k++) begin
        out_ready = rdy_seq[k];
        cycle();
      end
    end
    check_val("perf_fetch", {32'd0, fetch_count}, 64'd4);
    check_val("perf_stall", {32'd0, stall_count}, 64'd3);
`endif

    // Randomized phase
    for (int i = 0; i < 65536; i++) begin
      mem[i] = ($urandom_range(0, 23) == 0) ? HALT_W : ($urandom | 32'h0000_0001);
    end
    do_reset();
    start = 1'b1;
    for (int c = 0; c < 600; c++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 40))
                                                   : 16'(16'hFFF0 + 16'($urandom_range(0, 15)));
      cycle();
      start = ($urandom_range(0, 7) == 0);
    end
    redirect_valid = 1'b0;
    start          = 1'b0;

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
